// File: rtl/maxnet_pkg.sv
// Shared types for the MaxNet convergence detector: result codes and control states.
package maxnet_pkg;

    typedef enum logic [1:0] {
        STATUS_NONE     = 2'd0,
        STATUS_WIN      = 2'd1,
        STATUS_ALL_ZERO = 2'd2,
        STATUS_TIMEOUT  = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

endpackage

// File: rtl/maxnet_zero_scan.sv
// Per-channel nonzero detection on sign-magnitude activations, with survivor count
// and lowest surviving channel index. Purely combinational.
module maxnet_zero_scan #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N*W-1:0]         x,
    output logic [N-1:0]           nz_mask,
    output logic [$clog2(N+1)-1:0] nz_cnt,
    output logic [$clog2(N)-1:0]   nz_idx
);

    localparam int CW = $clog2(N+1);
    localparam int IW = $clog2(N);

    // Magnitude-only test so that -0 (sign bit alone) is treated as zero
    always_comb begin
        nz_mask = '0;
        for (int i = 0; i < N; i++) begin
            nz_mask[i] = |x[i*W +: W-1];
        end
    end

    // Population count and lowest-index survivor; scanning downward leaves the lowest hit
    always_comb begin
        nz_cnt = '0;
        nz_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            nz_cnt = nz_cnt + CW'(nz_mask[i]);
            nz_idx = nz_mask[i] ? IW'(i) : nz_idx;
        end
    end

endmodule

// File: rtl/maxnet_winner_detect.sv
// MaxNet convergence detector: counts accepted iterations and latches WIN, ALL_ZERO or
// TIMEOUT once the activation vector settles, collapses, or the iteration budget runs out.
module maxnet_winner_detect
    import maxnet_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int STABLE   = 2,
    parameter int MAX_ITER = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    input  logic [N*W-1:0]                  x,
    input  logic [N*W-1:0]                  a,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      status,
    output logic [$clog2(N)-1:0]            win_idx,
    output logic [W-1:0]                    win_val,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);
    localparam int TW = $clog2(MAX_ITER+1);
    localparam int SW = $clog2(STABLE+1);

    logic [N-1:0]   nz_mask_s;
    logic [CW-1:0]  nz_cnt_s;
    logic [IW-1:0]  nz_idx_s;
    logic [W-1:0]   a_sel_s;
    logic [TW-1:0]  iter_next_s;
    logic [SW-1:0]  streak_next_s;
    logic           all_zero_s;
    logic           single_s;
    logic           win_hit_s;
    logic           timeout_s;

    fsm_e           state_r;
    status_e        status_r;
    logic           busy_r;
    logic           done_r;
    logic [IW-1:0]  win_idx_r;
    logic [W-1:0]   win_val_r;
    logic [TW-1:0]  iter_count_r;
    logic [SW-1:0]  streak_r;
    logic [IW-1:0]  prev_idx_r;

    maxnet_zero_scan #(
        .N (N),
        .W (W)
    ) u_zero_scan (
        .x       (x),
        .nz_mask (nz_mask_s),
        .nz_cnt  (nz_cnt_s),
        .nz_idx  (nz_idx_s)
    );

    // Candidate value of the lowest surviving channel
    always_comb begin
        a_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            a_sel_s = (nz_idx_s == IW'(i)) ? a[i*W +: W] : a_sel_s;
        end
    end

    // Next-sample decisions; the streak restarts whenever the lone survivor changes
    always_comb begin
        iter_next_s = iter_count_r + TW'(1);
        all_zero_s  = ~|nz_mask_s;
        single_s    = (nz_cnt_s == CW'(1));
        if (single_s) begin
            if ((streak_r != '0) && (nz_idx_s == prev_idx_r)) begin
                streak_next_s = streak_r + SW'(1);
            end else begin
                streak_next_s = SW'(1);
            end
        end else begin
            streak_next_s = '0;
        end
        win_hit_s = single_s && (streak_next_s == SW'(STABLE));
        timeout_s = (iter_next_s == TW'(MAX_ITER));
    end

    // Control FSM with registered result outputs; collapse and win take precedence over timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            status_r     <= STATUS_NONE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            win_idx_r    <= '0;
            win_val_r    <= '0;
            iter_count_r <= '0;
            streak_r     <= '0;
            prev_idx_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r      <= RUN;
                        busy_r       <= 1'b1;
                        status_r     <= STATUS_NONE;
                        iter_count_r <= '0;
                        streak_r     <= '0;
                        prev_idx_r   <= '0;
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    if (in_valid) begin
                        iter_count_r <= iter_next_s;
                        streak_r     <= streak_next_s;
                        if (single_s) begin
                            prev_idx_r <= nz_idx_s;
                        end
                        if (all_zero_s) begin
                            state_r   <= DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            status_r  <= STATUS_ALL_ZERO;
                            win_idx_r <= '0;
                            win_val_r <= '0;
                        end else if (win_hit_s) begin
                            state_r   <= DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            status_r  <= STATUS_WIN;
                            win_idx_r <= nz_idx_s;
                            win_val_r <= a_sel_s;
                        end else if (timeout_s) begin
                            state_r   <= DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            status_r  <= STATUS_TIMEOUT;
                            win_idx_r <= '0;
                            win_val_r <= '0;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign status     = status_r;
    assign win_idx    = win_idx_r;
    assign win_val    = win_val_r;
    assign iter_count = iter_count_r;

endmodule

// File: tb/tb_maxnet_winner_detect.sv
// Self-checking bench: directed vector table, reset/abort sequence, and randomized runs
// compared against a sample-by-sample reference model.
module tb_maxnet_winner_detect;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int STABLE   = 2;
    localparam int MAX_ITER = 8;
    localparam int SB       = N*W;

    localparam logic [1:0] ST_NONE     = 2'd0;
    localparam logic [1:0] ST_WIN      = 2'd1;
    localparam logic [1:0] ST_ALL_ZERO = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [SB-1:0]   x;
    logic [SB-1:0]   a;
    logic            busy;
    logic            done;
    logic [1:0]      status;
    logic [1:0]      win_idx;
    logic [W-1:0]    win_val;
    logic [3:0]      iter_count;

    int n_pass  = 0;
    int n_total = 0;

    maxnet_winner_detect #(
        .N        (N),
        .W        (W),
        .STABLE   (STABLE),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .x          (x),
        .a          (a),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .win_idx    (win_idx),
        .win_val    (win_val),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            n;
        logic [1023:0] xs;
        logic [1:0]    st;
        logic [1:0]    idx;
        logic [31:0]   val;
        int            it;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [SB-1:0] s4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [1023:0] rep(input logic [SB-1:0] s, input int from, input int cnt);
        logic [1023:0] r;
        r = '0;
        for (int j = from; j < from + cnt; j++) r[j*SB +: SB] = s;
        return r;
    endfunction

    // Reference: walk the samples applying the convergence rules directly.
    function automatic void model(input logic [1023:0] xs, input logic [1023:0] as,
                                  output logic [1:0] st, output logic [1:0] idx,
                                  output logic [31:0] val, output int it);
        int run_len;
        int last;
        int cnt;
        int who;
        logic [31:0] v;
        st = ST_NONE; idx = 2'd0; val = 32'd0; it = 0;
        run_len = 0; last = -1;
        for (int k = 0; k < 8; k++) begin
            cnt = 0; who = -1;
            for (int ch = 0; ch < N; ch++) begin
                v = xs[k*SB + ch*W +: W];
                if (v[30:0] != 31'd0) begin
                    cnt++;
                    if (who < 0) who = ch;
                end
            end
            it = k + 1;
            if (cnt == 0) begin
                st = ST_ALL_ZERO;
                return;
            end
            if (cnt == 1) begin
                run_len = (run_len > 0 && who == last) ? run_len + 1 : 1;
                last = who;
                if (run_len == STABLE) begin
                    st  = ST_WIN;
                    idx = who[1:0];
                    val = as[k*SB + who*W +: W];
                    return;
                end
            end else begin
                run_len = 0;
            end
            if (it == MAX_ITER) begin
                st = ST_TIMEOUT;
                return;
            end
        end
    endfunction

    // One full run: start, feed samples (optionally with idle gaps carrying a stray start),
    // wait for done within a cycle budget, then check the result and its one-cycle pulse.
    task automatic run_one(input logic [1023:0] xs, input logic [1023:0] as, input int nmax,
                           input bit gaps, input logic [1:0] e_st, input logic [1:0] e_idx,
                           input logic [31:0] e_val, input int e_it);
        int k;
        int cyc;
        bit got;
        bit gap;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_status_clr", 64'(status), 64'(ST_NONE));
        chk("start_iter_clr", 64'(iter_count), 64'd0);
        k = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 3*MAX_ITER + 4) begin
            gap = gaps && ($urandom_range(0, 3) == 0);
            if (gap || k >= nmax) begin
                in_valid = 1'b0; x = '0; start = gap;
            end else begin
                in_valid = 1'b1; x = xs[k*SB +: SB]; a = as[k*SB +: SB]; k++;
            end
            @(negedge clk);
            start = 1'b0; cyc++;
            if (done) got = 1'b1;
            else chk("iter_track", 64'(iter_count), 64'(k));
        end
        if (!got) begin
            chk("done_seen", 64'(done), 64'd1);
        end else begin
            chk("status", 64'(status), 64'(e_st));
            chk("win_idx", 64'(win_idx), 64'(e_idx));
            chk("win_val", 64'(win_val), 64'(e_val));
            chk("iter_count", 64'(iter_count), 64'(e_it));
            chk("busy_at_done", 64'(busy), 64'd0);
        end
        start = gaps; in_valid = 1'b1; x = '0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("done_ignores_start", 64'(busy), 64'd0);
        chk("held_status", 64'(status), 64'(e_st));
        chk("held_idx", 64'(win_idx), 64'(e_idx));
        start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SB-1:0]  a_tab;
        logic [1023:0]  xs;
        logic [1023:0]  as;
        logic [1:0]     e_st;
        logic [1:0]     e_idx;
        logic [31:0]    e_val;
        logic [31:0]    nzv;
        logic [31:0]    zv;
        int             e_it;
        int             s;
        int             r;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; x = '0; a = '0;
        a_tab = s4(32'hA, 32'hB, 32'hC, 32'hD);

        vecs[0] = '{3, rep(s4(32'd5, 32'd3, 32'd0, 32'd0), 0, 1) | rep(s4(32'd2, 32'd0, 32'd0, 32'd0), 1, 1)
                       | rep(s4(32'd1, 32'd0, 32'd0, 32'd0), 2, 1), ST_WIN, 2'd0, 32'hA, 3};
        vecs[1] = '{1, rep(s4(32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000), 0, 1), ST_ALL_ZERO, 2'd0, 32'd0, 1};
        vecs[2] = '{8, rep(s4(32'd1, 32'd1, 32'd0, 32'd0), 0, 8), ST_TIMEOUT, 2'd0, 32'd0, 8};
        vecs[3] = '{8, rep(s4(32'd1, 32'd1, 32'd0, 32'd0), 0, 7), ST_ALL_ZERO, 2'd0, 32'd0, 8};
        vecs[4] = '{2, rep(s4(32'd0, 32'd0, 32'd0, 32'd9), 0, 2), ST_WIN, 2'd3, 32'hD, 2};
        vecs[5] = '{8, rep(s4(32'd1, 32'd1, 32'd0, 32'd0), 0, 6) | rep(s4(32'd0, 32'd1, 32'd0, 32'd0), 6, 2),
                    ST_WIN, 2'd1, 32'hB, 8};
        vecs[6] = '{3, rep(s4(32'd0, 32'd7, 32'd0, 32'd0), 0, 1) | rep(s4(32'd0, 32'd0, 32'd4, 32'd0), 1, 1)
                       | rep(s4(32'd0, 32'd0, 32'd2, 32'd0), 2, 1), ST_WIN, 2'd2, 32'hC, 3};

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", 64'(status), 64'(ST_NONE));
        chk("rst_win_idx", 64'(win_idx), 64'd0);
        chk("rst_win_val", 64'(win_val), 64'd0);
        chk("rst_iter", 64'(iter_count), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i].xs, rep(a_tab, 0, 8), vecs[i].n, (i % 2) == 1,
                    vecs[i].st, vecs[i].idx, vecs[i].val, vecs[i].it);
        end

        // Abort mid-run: the pending all-zero sample must not produce a result
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; x = s4(32'd1, 32'd1, 32'd0, 32'd0);
        @(negedge clk);
        chk("abort_iter_pre", 64'(iter_count), 64'd1);
        x = '0; rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_status", 64'(status), 64'(ST_NONE));
        chk("abort_win_idx", 64'(win_idx), 64'd0);
        chk("abort_win_val", 64'(win_val), 64'd0);
        chk("abort_iter", 64'(iter_count), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        for (int run = 0; run < 40; run++) begin
            s = $urandom_range(0, 3);
            xs = '0;
            for (int k = 0; k < 8; k++) begin
                r = $urandom_range(0, 11);
                if (r == 7) s = $urandom_range(0, 3);
                for (int ch = 0; ch < N; ch++) begin
                    zv  = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
                    nzv = $urandom;
                    if (nzv[30:0] == 31'd0) nzv = 32'd1;
                    if (r == 0)      xs[k*SB + ch*W +: W] = zv;
                    else if (r <= 7) xs[k*SB + ch*W +: W] = (ch == s) ? nzv : zv;
                    else             xs[k*SB + ch*W +: W] = ($urandom_range(0, 1) == 1) ? nzv : zv;
                end
            end
            for (int j = 0; j < 32; j++) as[j*32 +: 32] = $urandom;
            model(xs, as, e_st, e_idx, e_val, e_it);
            run_one(xs, as, 8, 1'b1, e_st, e_idx, e_val, e_it);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
